// File: rtl/cache_axi_master_if.sv
// AXI4 read/write bus between the cache controller and the memory fabric.
// The master modport is the cache side; the slave modport is the memory side.
interface cache_axi_master_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_master.sv
// Single-outstanding AXI4 master that turns cache pipeline requests
// (block/word loads and writes) into one AXI burst each.
//
// state | meaning
// IDLE  | waiting for a request; only state where req is sampled
// AR    | read address presented, waiting for arready
// R     | collecting read beats until rlast
// AW    | write address presented, waiting for awready
// W     | streaming write beats until the wlast handshake
// B     | waiting for the write response
// DONE  | one-cycle task_finish pulse, then back to IDLE
module cache_axi_master #(
  parameter int         BLOCK_WORDS = 4,
  parameter logic [3:0] AXI_ID      = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic [31:0]              ad,
  input  logic [32*BLOCK_WORDS-1:0] wblock,
  input  logic [31:0]              wword,
  input  logic [3:0]               wword_en,
  input  logic [2:0]               rword_en,
  output logic                     ready,
  output logic                     task_finish,
  output logic [32*BLOCK_WORDS-1:0] rblock,
  output logic [31:0]              rword,
  output logic                     err,
  cache_axi_master_if.master       axi
);

  localparam int CW  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int OFF = $clog2(4*BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_WORDS-1);
  localparam logic [31:0]   BLK_MASK  = ~((32'd1 << OFF) - 32'd1);

  localparam logic [2:0] REQ_LOAD_BLOCK  = 3'd1;
  localparam logic [2:0] REQ_LOAD_WORD   = 3'd2;
  localparam logic [2:0] REQ_WRITE_BLOCK = 3'd3;
  localparam logic [2:0] REQ_WRITE_WORD  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t                    state;
  logic                      is_block;
  logic [31:0]               addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [32*BLOCK_WORDS-1:0] wblock_q;
  logic [31:0]               wword_q;
  logic [3:0]                wstrb_q;
  logic [CW-1:0]             beat_cnt;
  logic [32*BLOCK_WORDS-1:0] rblock_q;
  logic [31:0]               rword_q;
  logic                      err_q;
  logic                      task_finish_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;

  logic req_ok;
  logic req_load;
  logic req_blk;
  logic wlast_c;

  always_comb begin
    req_ok   = (req >= REQ_LOAD_BLOCK) && (req <= REQ_WRITE_WORD);
    req_load = (req == REQ_LOAD_BLOCK) || (req == REQ_LOAD_WORD);
    req_blk  = (req == REQ_LOAD_BLOCK) || (req == REQ_WRITE_BLOCK);
    wlast_c  = is_block ? (beat_cnt == LAST_BEAT) : 1'b1;
  end

  // Acceptance is combinational so ready lands in the same cycle req is seen in IDLE.
  assign ready = (state == S_IDLE) && req_ok && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      is_block      <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      wblock_q      <= '0;
      wword_q       <= '0;
      wstrb_q       <= '0;
      beat_cnt      <= '0;
      rblock_q      <= '0;
      rword_q       <= '0;
      err_q         <= 1'b0;
      task_finish_q <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            is_block <= req_blk;
            addr_q   <= req_blk ? (ad & BLK_MASK) : ad;
            len_q    <= req_blk ? 8'(BLOCK_WORDS-1) : 8'd0;
            size_q   <= (req == REQ_LOAD_WORD) ? rword_en : 3'b010;
            wblock_q <= wblock;
            wword_q  <= wword;
            wstrb_q  <= wword_en;
            beat_cnt <= '0;
            if (req_load) begin
              arvalid_q <= 1'b1;
              state     <= S_AR;
            end else begin
              awvalid_q <= 1'b1;
              state     <= S_AW;
            end
          end
        end
        S_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (axi.rvalid) begin
            if (is_block) rblock_q[32*int'(beat_cnt) +: 32] <= axi.rdata;
            else          rword_q <= axi.rdata;
            if (axi.rresp != 2'b00) err_q <= 1'b1;
            // Overlong bursts keep landing in the last word instead of wrapping.
            if (beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + CW'(1);
            if (axi.rlast) begin
              rready_q      <= 1'b0;
              task_finish_q <= 1'b1;
              state         <= S_DONE;
            end
          end
        end
        S_AW: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state     <= S_W;
          end
        end
        S_W: begin
          if (axi.wready) begin
            if (wlast_c) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state    <= S_B;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        S_B: begin
          if (axi.bvalid) begin
            if (axi.bresp != 2'b00) err_q <= 1'b1;
            bready_q      <= 1'b0;
            task_finish_q <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          task_finish_q <= 1'b0;
          err_q         <= 1'b0;
          beat_cnt      <= '0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign task_finish = task_finish_q;
  assign err         = task_finish_q & err_q;
  assign rblock      = rblock_q;
  assign rword       = rword_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata   = is_block ? wblock_q[32*int'(beat_cnt) +: 32] : wword_q;
  assign axi.wstrb   = is_block ? 4'hF : wstrb_q;
  assign axi.wlast   = wvalid_q & wlast_c;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

endmodule
